booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier; next generation of the 16-bit data_path/control_path multiplier pair.
Adds generic WIDTH, a per-operation signed/unsigned mode, parallel operand load, and valid/ready handshakes on both input and output, with output backpressure.
Sits between an operand producer and a result consumer in the arithmetic datapath.
Produces one 2*WIDTH product per accepted operation, with a fixed latency.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_mult_dp.sv | 81 ++++++++
 rtl/booth_mult_seq.sv | 83 ++++++++
 tb/tb_booth_mult_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Holds FSM states, Booth op-select codes and the operand extension function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Widest operand the extension helper supports.
  localparam int MAX_W = 64;

  // Extends the low 'width' bits of op by one bit (and beyond): sign-fill when is_signed.
  function automatic logic [MAX_W:0] ext(input logic [MAX_W-1:0] op,
                                         input logic             is_signed,
                                         input int               width);
    logic [MAX_W:0] hi_mask;
    logic           fill;
    hi_mask = {(MAX_W+1){1'b1}} << width;
    fill    = is_signed & (|(op & (MAX_W'(1) << (width - 1))));
    return ({1'b0, op} & ~hi_mask) | (fill ? hi_mask : '0);
  endfunction

endpackage

// File: rtl/booth_mult_dp.sv
// Booth multiplier datapath: A/Q/M/qm1 registers, add/sub, arithmetic shift, iteration count.
// One iteration per 'step'; product latched on the final iteration; no flow control of its own.
// Backpressure is handled by the controller, which simply stops asserting load/step.
module booth_mult_dp
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               eqz,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     q_q;
  logic [WIDTH:0]     m_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   cnt_q;

  booth_op_t          op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     a_nx;
  logic [WIDTH:0]     q_nx;
  logic [2*WIDTH-1:0] prod_nx;

  always_comb begin
    op = NOP;
    case ({q_q[0], qm1_q})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase

    sum = a_q;
    if (op == ADD) begin
      sum = a_q + m_q;
    end else if (op == SUB) begin
      sum = a_q - m_q;
    end

    // Arithmetic right shift of {sum, Q, qm1}; qm1 picks up Q[0] in the register block.
    a_nx    = {sum[WIDTH], sum[WIDTH:1]};
    q_nx    = {sum[0], q_q[WIDTH:1]};
    prod_nx = {a_nx[WIDTH-2:0], q_nx};
  end

  assign eqz = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
    end else if (load) begin
      m_q   <= (WIDTH+1)'(ext(MAX_W'(multiplicand), is_signed, WIDTH));
      q_q   <= (WIDTH+1)'(ext(MAX_W'(multiplier), is_signed, WIDTH));
      a_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= CNT_W'(WIDTH + 1);
    end else if (step) begin
      a_q   <= a_nx;
      q_q   <= q_nx;
      qm1_q <= q_q[0];
      cnt_q <= cnt_q - CNT_W'(1);
      if (eqz) begin
        product <= prod_nx;
      end
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency WIDTH+1 edges from accept to out_valid; one op in flight, WIDTH+3 cycle best throughput.
// Product is held in DONE until out_ready; in_ready is low whenever an op is in flight.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  state_t state_q;
  state_t state_d;
  logic   load;
  logic   step;
  logic   eqz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (eqz) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = ~in_ready;

  booth_mult_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (step),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .eqz          (eqz),
    .product      (product)
  );

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboarded bench for booth_mult_seq at WIDTH=16 and WIDTH=8.
`timescale 1ns/1ps
module tb_booth_mult_seq;

  localparam int W  = 16;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;

  logic             in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [W-1:0]     multiplicand, multiplier;
  logic [2*W-1:0]   product;

  logic             in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
  logic [W8-1:0]    multiplicand8, multiplier8;
  logic [2*W8-1:0]  product8;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint exp_q[$];
  longint acc_q[$];
  longint exp8_q[$];
  longint acc8_q[$];
  bit     rand_ready = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  booth_mult_seq #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .multiplicand(multiplicand8), .multiplier(multiplier8), .is_signed(is_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic longint ref_mul(input int w, input longint m, input longint q, input bit s);
    longint a, b;
    a = m;
    b = q;
    if (s) begin
      if (m >= (longint'(1) << (w - 1))) a = m - (longint'(1) << w);
      if (q >= (longint'(1) << (w - 1))) b = q - (longint'(1) << w);
    end
    return (a * b) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input bit s);
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 300);
    if (!in_ready) begin
      fail("in_ready_timeout");
      return;
    end
    in_valid = 1'b1; multiplicand = m; multiplier = q; is_signed = s;
    @(posedge clk);
    exp_q.push_back(ref_mul(W, longint'(m), longint'(q), s));
    acc_q.push_back(longint'($time));
    #1;
    in_valid = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic issue8(input logic [W8-1:0] m, input logic [W8-1:0] q, input bit s);
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready8 && n < 300);
    if (!in_ready8) begin
      fail("in_ready8_timeout");
      return;
    end
    in_valid8 = 1'b1; multiplicand8 = m; multiplier8 = q; is_signed8 = s;
    @(posedge clk);
    exp8_q.push_back(ref_mul(W8, longint'(m), longint'(q), s));
    acc8_q.push_back(longint'($time));
    #1;
    in_valid8 = 1'b0;
    multiplicand8 = W8'($urandom); multiplier8 = W8'($urandom); is_signed8 = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0 || !in_ready || !in_ready8) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) fail("drain_timeout");
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor for the 16-bit instance.
  initial begin
    logic           pv, pr;
    logic [2*W-1:0] held;
    longint         e, t;
    pv = 1'b0; pr = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0; pr = 1'b0;
        continue;
      end
      check("busy_vs_in_ready", longint'(busy), longint'(!in_ready));
      if (pv && pr) check("idle_after_handshake", longint'({out_valid, busy, in_ready}), 64'd1);
      if (out_valid) begin
        check("in_ready_in_done", longint'(in_ready), 64'd0);
        if (!pv) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_product");
          end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check("product", longint'(product), e);
            check("latency_edges", (longint'($time) - 6 - t) / 10, longint'(W + 1));
          end
          held = product;
        end else begin
          check("product_stable", longint'(product), longint'(held));
        end
      end
      pv = out_valid;
      pr = out_ready;
    end
  end

  // Monitor for the 8-bit instance.
  initial begin
    logic   pv8;
    longint e, t;
    pv8 = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv8 = 1'b0;
        continue;
      end
      if (out_valid8 && !pv8) begin
        if (exp8_q.size() == 0) begin
          fail("unexpected_product8");
        end else begin
          e = exp8_q.pop_front();
          t = acc8_q.pop_front();
          check("product8", longint'(product8), e);
          check("latency_edges8", (longint'($time) - 6 - t) / 10, longint'(W8 + 1));
        end
      end
      pv8 = out_valid8;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; multiplicand = '0; multiplier = '0; is_signed = 1'b0;
    in_valid8 = 1'b0; multiplicand8 = '0; multiplier8 = '0; is_signed8 = 1'b0;
    out_ready8 = 1'b1;
    #2;
    check("rst_in_ready", longint'(in_ready), 64'd1);
    check("rst_out_valid", longint'(out_valid), 64'd0);
    check("rst_busy", longint'(busy), 64'd0);
    check("rst_product", longint'(product), 64'd0);
    check("rst_product8", longint'(product8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corners at WIDTH=16.
    issue(16'd15, 16'd10, 1'b0);
    issue(16'hFFFB, 16'd3, 1'b1);
    issue(16'h8000, 16'h8000, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    issue(16'd0, 16'hBEEF, 1'b1);
    issue(16'h1234, 16'd0, 1'b0);
    drain();

    // Hold the result with out_ready low while a new request is offered.
    out_ready = 1'b0;
    issue(W'($urandom), W'($urandom), 1'($urandom));
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    if (!out_valid) fail("out_valid_timeout");
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b1; multiplicand = W'($urandom); multiplier = W'($urandom); is_signed = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(16'd7, 16'd9, 1'b0);
    drain();

    // Abort an operation partway through with an asynchronous reset.
    in_valid = 1'b1; multiplicand = 16'd1234; multiplier = 16'd567; is_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_before_abort", longint'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_in_ready", longint'(in_ready), 64'd1);
    check("abort_out_valid", longint'(out_valid), 64'd0);
    check("abort_busy", longint'(busy), 64'd0);
    check("abort_product", longint'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'd1234, 16'd567, 1'b0);
    drain();

    // Random operands and modes with random output backpressure.
    rand_ready = 1'b1;
    repeat (40) issue(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // WIDTH=8 instance.
    issue8(8'h80, 8'd127, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b0);
    issue8(8'h80, 8'h80, 1'b1);
    repeat (10) issue8(W8'($urandom), W8'($urandom), 1'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
